fetch_stage: RTL and testbench

Instruction-fetch stage of the rv32i pipeline: owns the PC register, drives the instruction-memory request/response handshake and the IF/ID pipeline register. It sits directly upstream of decode and consumes the `pc_enable` / `ifid_enable` stall controls produced by the hazard unit, plus the taken-branch redirect from execute. One outstanding memory request at a time; a one-entry hold buffer absorbs a response that arrives while IF/ID is stalled.

---
 rtl/rv_pkg.sv | 36 +++
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared rv32i pipeline definitions: data width, canonical NOP, fetch FSM
// states and the IF/ID pipeline register layout.
package rv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // FETCH: a request may issue; WAIT: one request outstanding;
    // HOLD: response parked in the hold buffer while IF/ID is stalled.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifid_t;

    // Builds an IF/ID entry; a bubble is ifid_entry(1'b0, pc, NOP_INSTR).
    function automatic ifid_t ifid_entry(input logic            valid,
                                         input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] instr);
        ifid_t e;
        e.valid = valid;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel. The fetch stage is the
// master (issues requests, consumes responses); the memory is the slave.
interface fetch_stage_if;
    import rv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time, and fills the IF/ID register. A one-entry hold buffer absorbs a
// response that returns while IF/ID is stalled; a kill flag discards the
// response of a request that was in flight when a redirect happened.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_enable,
    input  logic              ifid_enable,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    fetch_stage_if.master     imem,
    output logic              ifid_valid,
    output logic [XLEN-1:0]   ifid_pc,
    output logic [XLEN-1:0]   ifid_instr
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] hold_q, hold_d;
    ifid_t           ifid_q, ifid_d;

    logic            accept;
    logic [XLEN-1:0] redirect_target;
    logic [1:0]      unused_redirect_lsbs;

    // Redirect targets are always word aligned; the low bits are ignored.
    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = redirect_pc[1:0];

    // Request is held high in FETCH until the memory takes it.
    assign imem.imem_req  = (state_q == FETCH) && pc_enable && !rst;
    assign imem.imem_addr = pc_q;
    assign accept         = imem.imem_req && imem.imem_ready;

    assign ifid_valid = ifid_q.valid;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_instr = ifid_q.instr;

    // Next-state, PC, kill flag, hold buffer and IF/ID contents.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        hold_d  = hold_q;
        ifid_d  = ifid_q;

        if (redirect_valid) begin
            // Redirect wins over every stall: flush IF/ID, retarget the PC,
            // and make sure any in-flight old-path response gets dropped.
            pc_d   = redirect_target;
            ifid_d = ifid_entry(1'b0, pc_q, NOP_INSTR);
            case (state_q)
                FETCH: begin
                    if (accept) begin
                        state_d = WAIT;
                        kill_d  = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        state_d = FETCH;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: begin
                    // HOLD: the buffered word is on the wrong path.
                    state_d = FETCH;
                    kill_d  = 1'b0;
                end
            endcase
        end else begin
            // Bubble unless a real instruction is delivered below.
            if (ifid_enable) begin
                ifid_d = ifid_entry(1'b0, pc_q, NOP_INSTR);
            end
            case (state_q)
                FETCH: begin
                    if (accept) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = FETCH;
                        end else if (ifid_enable) begin
                            ifid_d  = ifid_entry(1'b1, pc_q, imem.imem_rdata);
                            pc_d    = pc_q + XLEN'(4);
                            state_d = FETCH;
                        end else begin
                            hold_d  = imem.imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ifid_enable) begin
                        ifid_d  = ifid_entry(1'b1, pc_q, hold_q);
                        pc_d    = pc_q + XLEN'(4);
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // Control and architectural state, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from pre-edge values.
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            ifid_q  <= ifid_entry(1'b0, '0, NOP_INSTR);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            ifid_q  <= ifid_d;
        end
    end

    // Hold buffer data register.
    always_ff @(posedge clk) begin
        // NOTE: the hold buffer is pure data, only read in HOLD after being
        // written, so it carries no reset.
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetch stream.
module tb_fetch_stage;
    import rv_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_enable;
    logic        ifid_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_enable      (pc_enable),
        .ifid_enable    (ifid_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Memory model: responds with addr ^ KEY a fixed or random number of
    // cycles after each accepted request.
    bit          mem_auto   = 1'b0;
    bit          rand_ready = 1'b0;
    bit          rand_lat   = 1'b0;
    int          lat_fixed  = 1;
    bit          pend       = 1'b0;
    logic [31:0] pend_addr  = '0;
    int          cnt        = 0;

    // One clock: note the handshake, advance, then update the memory outputs.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = bus.imem_req && bus.imem_ready;
        a   = bus.imem_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            if (bus.imem_rvalid) begin
                pend            = 1'b0;
                bus.imem_rvalid = 1'b0;
            end
            if (acc) begin
                pend      = 1'b1;
                pend_addr = a;
                cnt       = rand_lat ? int'($urandom_range(1, 3)) : lat_fixed;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = pend_addr ^ KEY;
                end else begin
                    cnt--;
                end
            end
            bus.imem_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_enable = 1'b1; ifid_enable = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        tick(); tick();
        tests++; if (bus.imem_req !== 1'b0) begin failed++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        tests++; if (bus.imem_addr !== 32'h0) begin failed++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
        tests++; if (ifid_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
        tests++; if (ifid_pc !== 32'h0) begin failed++; $display("FAIL reset_pc: got %h want 0", ifid_pc); end
        tests++; if (ifid_instr !== NOP_INSTR) begin failed++; $display("FAIL reset_instr: got %h want %h", ifid_instr, NOP_INSTR); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc;
        mem_auto = 1'b1; rand_ready = 1'b0; rand_lat = 1'b0; lat_fixed = 1; pend = 1'b0;
        rst = 1'b0; #1;
        tests++; if (bus.imem_req !== 1'b1) begin failed++; $display("FAIL zw_req: got %b want 1", bus.imem_req); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k % 2 == 0) begin
                pc = 32'((k / 2 - 1) * 4);
                tests++; if (ifid_valid !== 1'b1 || ifid_pc !== pc || ifid_instr !== (pc ^ KEY)) begin
                    failed++; $display("FAIL zw_deliver c%0d: got %b/%h/%h want 1/%h/%h", k, ifid_valid, ifid_pc, ifid_instr, pc, pc ^ KEY);
                end
            end else begin
                tests++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP_INSTR) begin
                    failed++; $display("FAIL zw_bubble c%0d: got %b/%h want 0/%h", k, ifid_valid, ifid_instr, NOP_INSTR);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [64:0] snap;
        ifid_enable = 1'b0; #1;
        snap = {ifid_valid, ifid_pc, ifid_instr};
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if ({ifid_valid, ifid_pc, ifid_instr} !== snap) begin
                failed++; $display("FAIL hold_frozen c%0d: got %h want %h", k, {ifid_valid, ifid_pc, ifid_instr}, snap);
            end
            tests++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'hC) begin
                failed++; $display("FAIL hold_noreq c%0d: got %b/%h want 0/0000000c", k, bus.imem_req, bus.imem_addr);
            end
        end
        ifid_enable = 1'b1; #1;
        tick();
        tests++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'hC || ifid_instr !== (32'hC ^ KEY)) begin
            failed++; $display("FAIL hold_release: got %b/%h/%h want 1/0000000c/%h", ifid_valid, ifid_pc, ifid_instr, 32'hC ^ KEY);
        end
        tests++; if (bus.imem_addr !== 32'h10) begin failed++; $display("FAIL hold_pc_adv: got %h want 00000010", bus.imem_addr); end
    endtask

    task automatic test_pc_stall();
        pc_enable = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            tests++; if (bus.imem_req !== 1'b0) begin failed++; $display("FAIL stall_req c%0d: got %b want 0", k, bus.imem_req); end
            tick();
            tests++; if (bus.imem_addr !== 32'h10 || ifid_valid !== 1'b0 || ifid_pc !== 32'h10 || ifid_instr !== NOP_INSTR) begin
                failed++; $display("FAIL stall_bubble c%0d: got %h %b/%h/%h want 00000010 0/00000010/%h", k, bus.imem_addr, ifid_valid, ifid_pc, ifid_instr, NOP_INSTR);
            end
        end
        pc_enable = 1'b1; #1;
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0;
        lat_fixed = 3;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
        tick();
        redirect_valid = 1'b0; lat_fixed = 1; #1;
        tests++; if (bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b0) begin
            failed++; $display("FAIL rdw_addr: got %h/%b want 00000100/0", bus.imem_addr, bus.imem_req);
        end
        tests++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP_INSTR) begin
            failed++; $display("FAIL rdw_bubble: got %b/%h want 0/%h", ifid_valid, ifid_instr, NOP_INSTR);
        end
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) begin
                found = 1'b1;
                tests++; if (ifid_pc !== 32'h100 || ifid_instr !== (32'h100 ^ KEY) || i < 2) begin
                    failed++; $display("FAIL rdw_first: got %h/%h at +%0d want 00000100/%h at >=+2", ifid_pc, ifid_instr, i, 32'h100 ^ KEY);
                end
            end
        end
        if (!found) begin tests++; failed++; $display("FAIL rdw_timeout: got no instruction want one within 20 cycles"); end
    endtask

    task automatic test_redirect_rvalid();
        bit found = 1'b0;
        ifid_enable = 1'b0; #1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
        tick();
        redirect_valid = 1'b0; #1;
        tests++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP_INSTR) begin
            failed++; $display("FAIL rrv_flush: got %b/%h want 0/%h", ifid_valid, ifid_instr, NOP_INSTR);
        end
        tests++; if (bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1) begin
            failed++; $display("FAIL rrv_target: got %h/%b want 00000200/1", bus.imem_addr, bus.imem_req);
        end
        ifid_enable = 1'b1; #1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) begin
                found = 1'b1;
                tests++; if (ifid_pc !== 32'h200 || ifid_instr !== (32'h200 ^ KEY)) begin
                    failed++; $display("FAIL rrv_first: got %h/%h want 00000200/%h", ifid_pc, ifid_instr, 32'h200 ^ KEY);
                end
            end
        end
        if (!found) begin tests++; failed++; $display("FAIL rrv_timeout: got no instruction want one within 20 cycles"); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        lat_fixed = 2;
        ifid_enable = 1'b0; #1;
        tick();
        rst = 1'b1; #1;
        tick();
        tests++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== NOP_INSTR) begin
            failed++; $display("FAIL rmid_ifid: got %b/%h/%h want 0/00000000/%h", ifid_valid, ifid_pc, ifid_instr, NOP_INSTR);
        end
        tests++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
            failed++; $display("FAIL rmid_req: got %b/%h want 0/00000000", bus.imem_req, bus.imem_addr);
        end
        lat_fixed = 1; rst = 1'b0; ifid_enable = 1'b1; #1;
        tick();
        tests++; if (ifid_valid !== 1'b0) begin failed++; $display("FAIL rmid_late: got valid %b pc %h want 0", ifid_valid, ifid_pc); end
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) begin
                found = 1'b1;
                tests++; if (ifid_pc !== 32'h0 || ifid_instr !== KEY) begin
                    failed++; $display("FAIL rmid_first: got %h/%h want 00000000/%h", ifid_pc, ifid_instr, KEY);
                end
            end
        end
        if (!found) begin tests++; failed++; $display("FAIL rmid_timeout: got no instruction want one within 20 cycles"); end
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        pc_enable = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
        tick();
        redirect_valid = 1'b0; pc_enable = 1'b1; #1;
        tests++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_target: got %h want fffffffc", bus.imem_addr); end
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (ifid_valid === 1'b1) begin
                found = 1'b1;
                tests++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_instr !== (32'hFFFF_FFFC ^ KEY)) begin
                    failed++; $display("FAIL wrap_deliver: got %h/%h want fffffffc/%h", ifid_pc, ifid_instr, 32'hFFFF_FFFC ^ KEY);
                end
                tests++; if (bus.imem_addr !== 32'h0) begin failed++; $display("FAIL wrap_next: got %h want 00000000", bus.imem_addr); end
            end
        end
        if (!found) begin tests++; failed++; $display("FAIL wrap_timeout: got no instruction want one within 20 cycles"); end
    endtask

    // Model: the PC is the address of the next instruction in program order;
    // each delivered instruction must carry that PC and its memory word, then
    // the PC moves on by 4; a redirect replaces it and flushes IF/ID.
    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        logic [64:0] snap;
        logic [31:0] rt;
        bit          ie, rv;
        int          deliveries = 0;
        rst = 1'b1; tick(); tick();
        rst = 1'b0; pend = 1'b0; bus.imem_rvalid = 1'b0;
        rand_ready = 1'b1; rand_lat = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            pc_enable      = ($urandom_range(0, 9) < 8);
            ifid_enable    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            #1;
            tests++; if (bus.imem_addr !== exp_pc) begin failed++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.imem_addr, exp_pc); end
            tests++; if (bus.imem_req === 1'b1 && !pc_enable) begin failed++; $display("FAIL rnd_req c%0d: got req 1 want 0 with pc_enable 0", c); end
            snap = {ifid_valid, ifid_pc, ifid_instr};
            ie = ifid_enable; rv = redirect_valid; rt = redirect_pc;
            tick();
            if (rv) begin
                exp_pc = {rt[31:2], 2'b00};
                tests++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP_INSTR) begin
                    failed++; $display("FAIL rnd_flush c%0d: got %b/%h want 0/%h", c, ifid_valid, ifid_instr, NOP_INSTR);
                end
            end else if (ie) begin
                if (ifid_valid === 1'b1) begin
                    tests++; if (ifid_pc !== exp_pc || ifid_instr !== (exp_pc ^ KEY)) begin
                        failed++; $display("FAIL rnd_deliver c%0d: got %h/%h want %h/%h", c, ifid_pc, ifid_instr, exp_pc, exp_pc ^ KEY);
                    end
                    exp_pc = exp_pc + 32'd4;
                    deliveries++;
                end else begin
                    tests++; if (ifid_instr !== NOP_INSTR) begin failed++; $display("FAIL rnd_bubble c%0d: got %h want %h", c, ifid_instr, NOP_INSTR); end
                end
            end else begin
                tests++; if ({ifid_valid, ifid_pc, ifid_instr} !== snap) begin
                    failed++; $display("FAIL rnd_frozen c%0d: got %h want %h", c, {ifid_valid, ifid_pc, ifid_instr}, snap);
                end
            end
        end
        tests++; if (deliveries < 100) begin failed++; $display("FAIL rnd_progress: got %0d deliveries want >= 100", deliveries); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_hold();
        test_pc_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test want finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule
